// File: rtl/fll_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// fll_cfg_arbiter
//
// Shares the single FLL configuration port between two requesters (e.g. the
// boot sequencer and the APB SoC-control bridge). A round-robin grant picks
// one requester, its wrn/add/wdata are captured, and the full 4-phase req/ack
// handshake is run to the FLL. Both handshake phases are bounded by TIMEOUT
// cycles; an expired phase aborts the transfer with err_o=1. The block also
// synchronises the FLL lock output and keeps a sticky lock-lost flag.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i[1:0]          per-requester request, held until done_o[n]
//   wrn_i[1:0]          per-requester direction (1=read, 0=write)
//   add_i[3:0]          requester n address at add_i[2n+1:2n]
//   wdata_i[63:0]       requester n write data at wdata_i[32n+31:32n]
//   done_o[1:0]         one-cycle completion pulse per requester
//   err_o               with done_o: 1 = timeout abort
//   rdata_o[31:0]       with done_o: read data (0 for writes and aborts)
//   fll_req_o, fll_wrn_o, fll_add_o, fll_data_o
//                       FLL configuration port outputs
//   fll_ack_i, fll_r_data_i
//                       FLL configuration port inputs
//   fll_lock_i          FLL lock, asynchronous to clk_i
//   lock_o              synchronised lock
//   lock_lost_o         sticky flag: synchronised lock fell 1->0
//   lock_clr_i          clears lock_lost_o (a same-cycle fall wins)
// ---------------------------------------------------------------------------
module fll_cfg_arbiter #(
    parameter  int unsigned TIMEOUT = 255,
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  wrn_i,
    input  logic [3:0]  add_i,
    input  logic [63:0] wdata_i,
    output logic [1:0]  done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_r_data_i,
    input  logic        fll_lock_i,
    output logic        lock_o,
    output logic        lock_lost_o,
    input  logic        lock_clr_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last counter value tolerated in a handshake phase before aborting.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q;
    logic              gnt_q;        // requester owning the current transfer
    logic              prio_q;       // requester that wins a tie
    logic [CNT_W-1:0]  cnt_q;
    logic              fll_req_q;
    logic              fll_wrn_q;
    logic [1:0]        fll_add_q;
    logic [31:0]       fll_data_q;
    logic [31:0]       rdata_cap_q;  // read data latched on ack
    logic [1:0]        done_q;
    logic              err_q;
    logic [31:0]       rdata_q;

    logic              lock_meta_q;
    logic              lock_sync_q;
    logic              lock_lost_q;
    logic              lock_lost_d;

    logic              gnt_d;
    logic              sel_wrn;
    logic [1:0]        sel_add;
    logic [31:0]       sel_wdata;

    // Round-robin winner: a lone requester always wins, a tie goes to prio_q.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path
        // leaves it unassigned; a missing default infers a latch.
        gnt_d = prio_q;
        if (req_i == 2'b01) begin
            gnt_d = 1'b0;
        end else if (req_i == 2'b10) begin
            gnt_d = 1'b1;
        end
    end

    assign sel_wrn   = gnt_d ? wrn_i[1]       : wrn_i[0];
    assign sel_add   = gnt_d ? add_i[3:2]     : add_i[1:0];
    assign sel_wdata = gnt_d ? wdata_i[63:32] : wdata_i[31:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            fll_req_q   <= 1'b0;
            fll_wrn_q   <= 1'b0;
            fll_add_q   <= '0;
            fll_data_q  <= '0;
            rdata_cap_q <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            // Completion outputs are a single-cycle pulse: they are loaded
            // only on the transition into DONE and fall back to 0 otherwise.
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    // A still-high ack belongs to an aborted transfer; wait it out.
                    if ((req_i != 2'b00) && !fll_ack_i) begin
                        gnt_q      <= gnt_d;
                        fll_wrn_q  <= sel_wrn;
                        fll_add_q  <= sel_add;
                        fll_data_q <= sel_wdata;
                        fll_req_q  <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (fll_ack_i) begin
                        rdata_cap_q <= fll_wrn_q ? fll_r_data_i : '0;
                        fll_req_q   <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= REL;
                    end else if (cnt_q == CNT_LAST) begin
                        fll_req_q <= 1'b0;
                        done_q    <= gnt_q ? 2'b10 : 2'b01;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                REL: begin
                    if (!fll_ack_i) begin
                        done_q  <= gnt_q ? 2'b10 : 2'b01;
                        rdata_q <= rdata_cap_q;
                        state_q <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abort: read data is discarded even if it was captured.
                        done_q  <= gnt_q ? 2'b10 : 2'b01;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    prio_q  <= ~gnt_q;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Lock-lost is set on the synchronised 1->0 edge; a same-cycle clear loses.
    always_comb begin
        lock_lost_d = lock_lost_q;
        if (lock_sync_q && !lock_meta_q) begin
            lock_lost_d = 1'b1;
        end else if (lock_clr_i) begin
            lock_lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            lock_meta_q <= fll_lock_i;
            lock_sync_q <= lock_meta_q;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign fll_req_o   = fll_req_q;
    assign fll_wrn_o   = fll_wrn_q;
    assign fll_add_o   = fll_add_q;
    assign fll_data_o  = fll_data_q;
    assign lock_o      = lock_sync_q;
    assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fll_cfg_arbiter
//
// Directed bench for fll_cfg_arbiter with TIMEOUT=8. A small FLL model acks
// a request after a programmable delay and releases ack after another delay.
// Single transfers come from a vector table; arbitration, stale ack, reset
// mid-transfer and the lock path are hand-written sequences. Inputs and DUT
// outputs are handled on the falling clock edge; the FLL model acts 2 ns after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_fll_cfg_arbiter;

    localparam int unsigned TIMEOUT = 8;
    localparam logic [31:0] JUNK    = 32'hA5A5_A5A5;
    localparam int          NVEC    = 8;

    logic        clk;
    logic        rst_i;
    logic [1:0]  req_i;
    logic [1:0]  wrn_i;
    logic [3:0]  add_i;
    logic [63:0] wdata_i;
    logic [1:0]  done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        fll_req_o;
    logic        fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o;
    logic        fll_ack_i;
    logic [31:0] fll_r_data_i;
    logic        fll_lock_i;
    logic        lock_o;
    logic        lock_lost_o;
    logic        lock_clr_i;

    fll_cfg_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .wrn_i        (wrn_i),
        .add_i        (add_i),
        .wdata_i      (wdata_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .fll_req_o    (fll_req_o),
        .fll_wrn_o    (fll_wrn_o),
        .fll_add_o    (fll_add_o),
        .fll_data_o   (fll_data_o),
        .fll_ack_i    (fll_ack_i),
        .fll_r_data_i (fll_r_data_i),
        .fll_lock_i   (fll_lock_i),
        .lock_o       (lock_o),
        .lock_lost_o  (lock_lost_o),
        .lock_clr_i   (lock_clr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- FLL configuration port model ----------------
    // Ack rises on the (ack_dly+1)-th cycle req is seen high; it falls on the
    // (rel_dly+1)-th cycle req is seen low. m_force holds ack high.
    int          m_ack_dly = 1;
    int          m_rel_dly = 1;
    logic [31:0] m_rdata   = JUNK;
    bit          m_force   = 1'b0;

    initial begin
        int acnt;
        int rcnt;
        acnt = 0;
        rcnt = 0;
        fll_ack_i    = 1'b0;
        fll_r_data_i = JUNK;
        forever begin
            @(posedge clk);
            #2;
            if (m_force) begin
                fll_ack_i = 1'b1;
                acnt = 0;
                rcnt = 0;
            end else if (fll_req_o && !fll_ack_i) begin
                acnt++;
                if (acnt > m_ack_dly) begin
                    fll_ack_i    = 1'b1;
                    fll_r_data_i = m_rdata;
                    acnt = 0;
                end
            end else if (!fll_req_o && fll_ack_i) begin
                rcnt++;
                if (rcnt > m_rel_dly) begin
                    fll_ack_i    = 1'b0;
                    fll_r_data_i = JUNK;
                    rcnt = 0;
                end
            end else begin
                acnt = 0;
                rcnt = 0;
            end
        end
    end

    // ---------------- single-transfer vectors ----------------
    // lat: falling edges from driving req_i until done_o is seen.
    // req_cyc: number of falling edges with fll_req_o high.
    typedef struct {
        logic [1:0]  req;
        logic        wrn;
        logic [1:0]  add;
        logic [31:0] wdata;
        int          ack_dly;
        int          rel_dly;
        logic [31:0] fll_rdata;
        logic [1:0]  exp_done;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_req_cyc;
    } vec_t;

    vec_t vecs [NVEC];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        bit          got;
        int          lat;
        int          req_cyc;
        int          hold_bad;
        int          bad;
        logic [1:0]  d;
        logic        e;
        logic [31:0] r;
        int          n_done;
        int          dbl;
        bit          prev_done;
        logic [1:0]  arb_done [4];
        logic [31:0] arb_rdata [4];
        logic [1:0]  arb_add [4];
        int          arb_c [4];
        logic [1:0]  exp_ord [4];
        logic [31:0] exp_rd [4];
        logic [1:0]  exp_ad [4];
        int          exp_c [4];

        //           req    wrn   add   wdata         a    r   fll_rdata     done   err   rdata         lat req_cyc
        vecs[0] = '{2'b01, 1'b0, 2'd2, 32'hDEADBEEF,   3,  2, 32'h55AA55AA, 2'b01, 1'b0, 32'h00000000,  8, 4}; // write
        vecs[1] = '{2'b10, 1'b1, 2'd1, 32'h00000000,   1,  1, 32'h12345678, 2'b10, 1'b0, 32'h12345678,  5, 2}; // read, min spec latency
        vecs[2] = '{2'b01, 1'b1, 2'd3, 32'h0F0F0F0F,   0,  0, 32'h87654321, 2'b01, 1'b0, 32'h87654321,  3, 1}; // fastest FLL
        vecs[3] = '{2'b10, 1'b0, 2'd0, 32'hFEEDFACE,   7,  1, 32'h77777777, 2'b10, 1'b0, 32'h00000000, 11, 8}; // ack on last REQ cycle
        vecs[4] = '{2'b01, 1'b1, 2'd1, 32'h31415926, 100,  1, 32'h99999999, 2'b01, 1'b1, 32'h00000000,  9, 8}; // never acks
        vecs[5] = '{2'b10, 1'b1, 2'd2, 32'h27182818,   8,  1, 32'h66666666, 2'b10, 1'b1, 32'h00000000,  9, 8}; // ack one cycle too late
        vecs[6] = '{2'b10, 1'b1, 2'd3, 32'h00C0FFEE,   1,  7, 32'h13579BDF, 2'b10, 1'b0, 32'h13579BDF, 11, 2}; // release on last REL cycle
        vecs[7] = '{2'b01, 1'b1, 2'd0, 32'h0DDBA11F,   1,  8, 32'h2468ACE0, 2'b01, 1'b1, 32'h00000000, 11, 2}; // release too late

        rst_i      = 1'b0;
        req_i      = '0;
        wrn_i      = '0;
        add_i      = '0;
        wdata_i    = '0;
        fll_lock_i = 1'b0;
        lock_clr_i = 1'b0;
        #2 rst_i = 1'b1;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        check("rst_done",   {29'd0, done_o, err_o}, 32'd0);
        check("rst_rdata",  rdata_o, 32'd0);
        check("rst_fll",    {28'd0, fll_req_o, fll_wrn_o, fll_add_o}, 32'd0);
        check("rst_fdata",  fll_data_o, 32'd0);
        check("rst_lock",   {30'd0, lock_o, lock_lost_o}, 32'd0);
        rst_i = 1'b0;

        // ---------------- table-driven single transfers ----------------
        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            m_ack_dly = v.ack_dly;
            m_rel_dly = v.rel_dly;
            m_rdata   = v.fll_rdata;
            // The idle requester's lanes carry inverted values to expose mux errors.
            if (v.req[1]) begin
                wrn_i   = {v.wrn, ~v.wrn};
                add_i   = {v.add, ~v.add};
                wdata_i = {v.wdata, ~v.wdata};
            end else begin
                wrn_i   = {~v.wrn, v.wrn};
                add_i   = {~v.add, v.add};
                wdata_i = {~v.wdata, v.wdata};
            end
            req_i    = v.req;
            got      = 1'b0;
            lat      = 0;
            req_cyc  = 0;
            hold_bad = 0;
            d = '0;
            e = 1'b0;
            r = '0;
            for (int c = 1; c <= 40 && !got; c++) begin
                @(negedge clk);
                if (fll_req_o) begin
                    req_cyc++;
                    if (fll_wrn_o !== v.wrn || fll_add_o !== v.add || fll_data_o !== v.wdata)
                        hold_bad++;
                end
                if (done_o != 2'b00) begin
                    got = 1'b1;
                    lat = c;
                    d   = done_o;
                    e   = err_o;
                    r   = rdata_o;
                    if (fll_add_o !== v.add || fll_data_o !== v.wdata)
                        hold_bad++;
                    req_i = 2'b00;
                end
            end
            req_i = 2'b00;
            check($sformatf("v%0d_seen", i),    {31'd0, got}, 32'd1);
            check($sformatf("v%0d_done", i),    {30'd0, d}, {30'd0, v.exp_done});
            check($sformatf("v%0d_err", i),     {31'd0, e}, {31'd0, v.exp_err});
            check($sformatf("v%0d_rdata", i),   r, v.exp_rdata);
            check($sformatf("v%0d_lat", i),     lat, v.exp_lat);
            check($sformatf("v%0d_req_cyc", i), req_cyc, v.exp_req_cyc);
            check($sformatf("v%0d_hold", i),    hold_bad, 0);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), {29'd0, done_o, err_o}, 32'd0);
            check($sformatf("v%0d_rd_clr", i), rdata_o, 32'd0);
            for (int c = 0; c < 30 && fll_ack_i; c++) @(negedge clk);
            check($sformatf("v%0d_ack_idle", i), {31'd0, fll_ack_i}, 32'd0);
        end

        // ---------------- stale ack blocks the grant ----------------
        m_ack_dly = 1;
        m_rel_dly = 1;
        m_rdata   = 32'h44444444;
        m_force   = 1'b1;
        repeat (2) @(negedge clk);
        check("stale_ack_up", {31'd0, fll_ack_i}, 32'd1);
        wrn_i   = 2'b00;
        add_i   = 4'b0001;
        wdata_i = {32'h0, 32'h0BADF00D};
        req_i   = 2'b01;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (fll_req_o) bad++;
        end
        check("stale_gate", bad, 0);
        m_force = 1'b0;
        got = 1'b0;
        d = '0;
        e = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (done_o != 2'b00) begin
                got = 1'b1;
                d = done_o;
                e = err_o;
                req_i = 2'b00;
            end
        end
        req_i = 2'b00;
        check("stale_done", {30'd0, d}, 32'd1);
        check("stale_err", {31'd0, e}, 32'd0);
        @(negedge clk);
        for (int c = 0; c < 30 && fll_ack_i; c++) @(negedge clk);

        // ---------------- reset in REQ ----------------
        // Requester 0 was served last, so only a reset brings priority back to 0.
        m_ack_dly = 100;
        wrn_i   = 2'b00;
        add_i   = 4'b0010;
        wdata_i = {32'h0, 32'h5A5A0001};
        req_i   = 2'b01;
        got = 1'b0;
        for (int c = 1; c <= 5 && !got; c++) begin
            @(negedge clk);
            if (fll_req_o) got = 1'b1;
        end
        check("rst_mid_req_seen", {31'd0, got}, 32'd1);
        #1 rst_i = 1'b1;
        req_i = 2'b00;
        #1;
        check("rst_mid_fll_req", {31'd0, fll_req_o}, 32'd0);
        check("rst_mid_done", {30'd0, done_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        m_ack_dly = 1;
        m_rel_dly = 1;

        // ---------------- round-robin, back-to-back ----------------
        m_rdata = 32'hCAFEF00D;
        wrn_i   = 2'b10;
        add_i   = {2'd1, 2'd2};
        wdata_i = {32'h22222222, 32'h11111111};
        exp_ord = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_rd  = '{32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D};
        exp_ad  = '{2'd2, 2'd1, 2'd2, 2'd1};
        exp_c   = '{5, 11, 17, 23};
        for (int k = 0; k < 4; k++) begin
            arb_done[k]  = '0;
            arb_rdata[k] = '1;
            arb_add[k]   = '0;
            arb_c[k]     = 0;
        end
        req_i = 2'b11;
        n_done = 0;
        dbl = 0;
        prev_done = 1'b0;
        for (int c = 1; c <= 60 && n_done < 4; c++) begin
            @(negedge clk);
            if (done_o != 2'b00) begin
                if (prev_done) dbl++;
                arb_done[n_done]  = done_o;
                arb_rdata[n_done] = rdata_o;
                arb_add[n_done]   = fll_add_o;
                arb_c[n_done]     = c;
                n_done++;
                if (n_done == 4) req_i = 2'b00;
            end
            prev_done = (done_o != 2'b00);
        end
        req_i = 2'b00;
        check("arb_count", n_done, 4);
        check("arb_single_cycle", dbl, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("arb%0d_grant", k), {30'd0, arb_done[k]}, {30'd0, exp_ord[k]});
            check($sformatf("arb%0d_rdata", k), arb_rdata[k], exp_rd[k]);
            check($sformatf("arb%0d_add", k),   {30'd0, arb_add[k]}, {30'd0, exp_ad[k]});
            check($sformatf("arb%0d_cycle", k), arb_c[k], exp_c[k]);
        end
        @(negedge clk);
        check("arb_idle", {31'd0, fll_req_o}, 32'd0);

        // ---------------- lock synchroniser and sticky flag ----------------
        fll_lock_i = 1'b1;
        @(negedge clk);
        check("lock_rise_d1", {31'd0, lock_o}, 32'd0);
        @(negedge clk);
        check("lock_rise_d2", {31'd0, lock_o}, 32'd1);
        check("lock_lost_idle", {31'd0, lock_lost_o}, 32'd0);
        fll_lock_i = 1'b0;
        @(negedge clk);
        check("lock_fall_d1", {30'd0, lock_o, lock_lost_o}, 32'd2);
        @(negedge clk);
        check("lock_fall_d2", {30'd0, lock_o, lock_lost_o}, 32'd1);
        repeat (3) @(negedge clk);
        check("lock_lost_sticky", {31'd0, lock_lost_o}, 32'd1);
        lock_clr_i = 1'b1;
        @(negedge clk);
        lock_clr_i = 1'b0;
        check("lock_lost_clr", {31'd0, lock_lost_o}, 32'd0);
        fll_lock_i = 1'b1;
        repeat (3) @(negedge clk);
        check("lock_relock", {31'd0, lock_o}, 32'd1);
        fll_lock_i = 1'b0;
        @(negedge clk);
        lock_clr_i = 1'b1;
        check("lock_pre_collide", {31'd0, lock_lost_o}, 32'd0);
        @(negedge clk);
        lock_clr_i = 1'b0;
        check("lock_set_wins", {30'd0, lock_o, lock_lost_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fll_cfg_arbiter.md
Name: fll_cfg_arbiter

Overview:
Shares the single FLL configuration port (req/ack, wrn, 2-bit address, 32-bit data) between two requesters, for example the boot sequencer and the APB SoC-control bridge.
It runs the full 4-phase req/ack handshake to the FLL, bounds every transfer with a timeout, and returns read data and error status to the winning requester.
It also synchronises the FLL lock output and keeps a sticky lock-lost flag.
It sits beside the clock/reset generator and drives its fll_* configuration inputs.

Parameters:
TIMEOUT, 255, maximum cycles spent waiting in either handshake phase before the transfer aborts (>=2)
CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
clk_i  in  1  single clock domain
rst_i  in  1  reset, asynchronous assert, active-high
req_i  in  2  per-requester transfer request; held high until done_o[n]
wrn_i  in  2  per-requester direction: 1=read, 0=write (FLL CFGWEB polarity)
add_i  in  2x2  per-requester register address
wdata_i  in  2x32  per-requester write data
done_o  out  2  one-cycle completion pulse per requester
err_o  out  1  valid with done_o: 1 = timeout abort
rdata_o  out  32  read data, valid with done_o (0 for writes and aborts)
fll_req_o  out  1  to FLL cfg req
fll_wrn_o  out  1  to FLL cfg wrn
fll_add_o  out  2  to FLL cfg address
fll_data_o  out  32  to FLL cfg write data
fll_ack_i  in  1  from FLL cfg ack
fll_r_data_i  in  32  from FLL cfg read data
fll_lock_i  in  1  FLL lock (asynchronous)
lock_o  out  1  synchronised lock
lock_lost_o  out  1  sticky: synchronised lock fell 1->0
lock_clr_i  in  1  clears lock_lost_o

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; round-robin pointer points at requester 0; counter 0; synchroniser flops 0.
- Requester contract: wrn_i/add_i/wdata_i must stay stable while req_i[n]=1. Dropping req_i before done_o is illegal. The captured copy is used regardless.
- FSM states: IDLE, REQ, REL, DONE.
- IDLE: waits for any req_i=1 AND fll_ack_i=0.
  - Grant goes to the round-robin winner: priority goes to the requester not served last; on a tie at reset, requester 0 wins.
  - On grant, capture wrn/add/wdata into fll_*_o, set fll_req_o=1, clear the counter, go to REQ. fll_req_o rises the cycle after req_i is sampled.
  - If fll_ack_i=1 (stale ack from an aborted transfer), stay in IDLE.
- REQ: fll_req_o=1.
  - If fll_ack_i=1: capture fll_r_data_i when wrn=1 (0 otherwise), clear fll_req_o, clear the counter, go to REL.
  - Else the counter increments. When the counter reaches TIMEOUT-1 without ack: fll_req_o=0, set the error flag, go to DONE.
- REL: fll_req_o=0.
  - If fll_ack_i=0: go to DONE.
  - Else the counter increments. When it reaches TIMEOUT-1: set the error flag, go to DONE.
- DONE: for one cycle, done_o[granted]=1, err_o=error flag, rdata_o=captured data (forced 0 when err). Update the round-robin pointer, clear the error flag, go to IDLE. done_o/err_o/rdata_o return to 0 the next cycle.
- Minimum latency: req_i sampled at cycle 0, with ack 1 cycle after req and ack release 1 cycle after req drop, gives done_o at cycle 5.
- Back-to-back: a requester may hold req_i high through done_o to request again. It then competes by round-robin in IDLE; no idle cycle beyond IDLE itself.
- fll_wrn_o/fll_add_o/fll_data_o hold their captured values until the next grant. They never change while fll_req_o=1.
- Lock path:
  - 2-flop synchroniser drives lock_o.
  - lock_lost_o is set when synced lock goes 1->0.
  - lock_clr_i clears it; a simultaneous set and clear gives set.
- Reset mid-transfer: all state returns to reset values immediately and fll_req_o drops asynchronously. A post-reset stale ack is handled by the IDLE ack=0 gate.

Test Plan:
- Write: req_i=01, wrn=0, add=2, wdata=0xDEADBEEF; FLL model acks after 3 cycles, releases after 2 -> fll_add_o=2, fll_data_o=0xDEADBEEF held throughout; done_o=01, err_o=0, rdata_o=0.
- Read: req_i=10, wrn=1, add=1, model returns 0x12345678 with ack -> done_o=10, rdata_o=0x12345678, err_o=0; 1 cycle later rdata_o=0.
- Arbitration: req_i=11 held for 4 transfers -> grant order 0,1,0,1; each done_o single-cycle; no fll_req_o overlap.
- Timeout: TIMEOUT=8, model never acks -> fll_req_o high for exactly 8 cycles, then done_o with err_o=1, rdata_o=0. Then with a stale ack held high 5 cycles, the next req is not granted until ack=0.
- Lock: toggle fll_lock_i 0->1->0 -> lock_o follows with 2-cycle delay; lock_lost_o=1 until lock_clr_i pulse. Clear in the same cycle as a new fall -> stays 1.
- Reset in REQ: assert rst_i while fll_req_o=1 -> fll_req_o=0 and done_o=0 immediately; after release, pointer back at requester 0.
